// File: rtl/instr_fetch_decode_if.sv
// Bundle of memory-fetch, issue and redirect signals for instr_fetch_decode.
// master = fetch/decode stage, slave = memory + execute environment.
interface instr_fetch_decode_if #(
  parameter int unsigned WIDTH = 16
);
  logic             mem_req;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ack;

  logic             issue_valid;
  logic             issue_ready;
  logic [3:0]       issue_opcode;
  logic [3:0]       issue_dest;
  logic [3:0]       issue_src;
  logic [3:0]       issue_ext;
  logic [WIDTH-1:0] issue_imm;
  logic [2:0]       issue_alu_c;
  logic [WIDTH-1:0] issue_pc;

  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_pc;
  logic             halt;

  modport master (
    output mem_req, mem_addr,
    input  mem_rdata, mem_ack,
    output issue_valid, issue_opcode, issue_dest, issue_src, issue_ext,
    output issue_imm, issue_alu_c, issue_pc,
    input  issue_ready,
    input  redirect_valid, redirect_pc,
    output halt
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_rdata, mem_ack,
    input  issue_valid, issue_opcode, issue_dest, issue_src, issue_ext,
    input  issue_imm, issue_alu_c, issue_pc,
    output issue_ready,
    output redirect_valid, redirect_pc,
    input  halt
  );
endinterface

// File: rtl/instr_fetch_decode.sv
// Fetch/decode front end: fetches 1-2 words, decodes, issues over valid/ready.
// Optional FETCH_STATS_EN adds issue_count / redirect_count output counters.
module instr_fetch_decode #(
  parameter int unsigned    WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic reset,
`ifdef FETCH_STATS_EN
  output logic [15:0] issue_count,
  output logic [15:0] redirect_count,
`endif
  instr_fetch_decode_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_IMM_FETCH,
    S_IMM_WAIT,
    S_ISSUE,
    S_HALTED
  } state_e;

  localparam logic [3:0] OP_LI = 4'b1100;
  localparam logic [3:0] OP_SY = 4'b1111;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic [WIDTH-1:0] ipc_q, ipc_d;
  logic             discard_q, discard_d;
  logic             halt_q, halt_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      addr_q    <= '0;
      ir_q      <= '0;
      imm_q     <= '0;
      ipc_q     <= '0;
      discard_q <= 1'b0;
      halt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      ir_q      <= ir_d;
      imm_q     <= imm_d;
      ipc_q     <= ipc_d;
      discard_q <= discard_d;
      halt_q    <= halt_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    ir_d      = ir_q;
    imm_d     = imm_q;
    ipc_d     = ipc_q;
    discard_d = discard_q;
    halt_d    = halt_q;

    unique case (state_q)
      S_FETCH: begin
        if (bus.redirect_valid) begin
          pc_d = bus.redirect_pc;
        end else begin
          addr_d  = pc_q;
          state_d = S_WAIT;
        end
      end

      // An outstanding request always completes; a redirect seen before or
      // with the ack turns the returned word into a discard.
      S_WAIT: begin
        if (bus.mem_ack) begin
          if (bus.redirect_valid || discard_q) begin
            if (bus.redirect_valid) pc_d = bus.redirect_pc;
            discard_d = 1'b0;
            state_d   = S_FETCH;
          end else begin
            ir_d    = bus.mem_rdata;
            ipc_d   = pc_q;
            pc_d    = pc_q + 1'b1;
            imm_d   = '0;
            state_d = (bus.mem_rdata[15:12] == OP_LI) ? S_IMM_FETCH : S_ISSUE;
          end
        end else if (bus.redirect_valid) begin
          pc_d      = bus.redirect_pc;
          discard_d = 1'b1;
        end
      end

      S_IMM_FETCH: begin
        if (bus.redirect_valid) begin
          pc_d    = bus.redirect_pc;
          state_d = S_FETCH;
        end else begin
          addr_d  = pc_q;
          state_d = S_IMM_WAIT;
        end
      end

      S_IMM_WAIT: begin
        if (bus.mem_ack) begin
          if (bus.redirect_valid || discard_q) begin
            if (bus.redirect_valid) pc_d = bus.redirect_pc;
            discard_d = 1'b0;
            state_d   = S_FETCH;
          end else begin
            imm_d   = bus.mem_rdata;
            pc_d    = pc_q + 1'b1;
            state_d = S_ISSUE;
          end
        end else if (bus.redirect_valid) begin
          pc_d      = bus.redirect_pc;
          discard_d = 1'b1;
        end
      end

      // Redirect beats the handshake, so a dropped sy never sets halt.
      S_ISSUE: begin
        if (bus.redirect_valid) begin
          pc_d    = bus.redirect_pc;
          state_d = S_FETCH;
        end else if (bus.issue_ready) begin
          if (ir_q[15:12] == OP_SY) begin
            halt_d  = 1'b1;
            state_d = S_HALTED;
          end else begin
            state_d = S_FETCH;
          end
        end
      end

      S_HALTED: state_d = S_HALTED;

      default: state_d = S_FETCH;
    endcase
  end

  // Outputs
  always_comb begin
    bus.mem_req      = (state_q == S_WAIT) || (state_q == S_IMM_WAIT);
    bus.mem_addr     = addr_q;
    bus.issue_valid  = (state_q == S_ISSUE);
    bus.issue_opcode = ir_q[15:12];
    bus.issue_dest   = ir_q[11:8];
    bus.issue_src    = ir_q[7:4];
    bus.issue_ext    = ir_q[3:0];
    bus.issue_imm    = imm_q;
    bus.issue_pc     = ipc_q;
    bus.halt         = halt_q;
    unique case (ir_q[15:12])
      4'b0000: bus.issue_alu_c = 3'd0;
      4'b0001: bus.issue_alu_c = 3'd1;
      4'b0010: bus.issue_alu_c = 3'd2;
      4'b0100: bus.issue_alu_c = 3'd3;
      4'b0011: bus.issue_alu_c = 3'd4;
      default: bus.issue_alu_c = 3'd7;
    endcase
  end

`ifdef FETCH_STATS_EN
  logic        issue_hs;
  logic        redirect_acc;
  logic [15:0] issue_cnt_q, redirect_cnt_q;

  assign issue_hs     = (state_q == S_ISSUE) && bus.issue_ready && !bus.redirect_valid;
  assign redirect_acc = bus.redirect_valid && (state_q != S_HALTED);

  always_ff @(posedge clk) begin
    if (!reset) begin
      issue_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      if (issue_hs)     issue_cnt_q    <= issue_cnt_q + 16'd1;
      if (redirect_acc) redirect_cnt_q <= redirect_cnt_q + 16'd1;
    end
  end

  assign issue_count    = issue_cnt_q;
  assign redirect_count = redirect_cnt_q;
`endif

endmodule
